// File: rtl/uart_tx_pkg.sv
// Shared register offsets, bit indices and shifter states for the UART TX peripheral.
// UART_TX_PARITY_EN adds the PARITY shifter state.
package uart_tx_pkg;

    localparam logic [2:0] OFF_TXDATA = 3'd0;
    localparam logic [2:0] OFF_CTRL   = 3'd1;
    localparam logic [2:0] OFF_DIVLO  = 3'd2;
    localparam logic [2:0] OFF_DIVHI  = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;
    // Offset 7 is reserved and doubles as the "no register selected" code.
    localparam logic [2:0] OFF_NONE   = 3'd7;

    localparam int CTRL_IE    = 0;
    localparam int CTRL_PAR   = 1;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO with show-ahead output; a push while full is accepted
// only when a pop happens in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == (AW+1)'(1'b0));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy update.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1'b1) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? rd_ptr_q + AW'(1'b1) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1'b1);
            2'b01:   count_d = count_q - (AW+1)'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset discards all queued bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: byte-lane register block, TX FIFO and 8N1 shifter.
// Define UART_TX_PARITY_EN to make CTRL.PAR writable and add an even-parity bit.
module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter logic [15:0] BASEADDR    = 16'h0010,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dread_addr,
    output logic [15:0] dread_data,
    input  logic [15:0] dwrite_addr,
    input  logic [15:0] dwrite_data,
    input  logic [1:0]  dwrite_en,
    output logic        txd,
    output logic        interrupt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [15:0]   baud_q, baud_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          ctrl_ie_q, ctrl_ie_d, ctrl_par_q, ctrl_par_d;
    logic          ovf_q, ovf_d, txd_q, txd_d, irq_q, irq_d;

    logic          push_s, pop_s, ovf_clr_s, busy_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [7:0]    fifo_dout_s, status_s, ctrl_s;
    logic [CW-1:0] fifo_count_s;
    logic [15:0]   waddr1_s;
    logic [1:0][2:0] wsel_s;

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (dwrite_data[7:0]),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    function automatic logic [7:0] reg_byte(input logic [15:0] addr, input logic [7:0] ctrl,
                                            input logic [15:0] div, input logic [7:0] status);
        logic [7:0] b;
        if (addr[15:3] == BASEADDR[15:3]) begin
            case (addr[2:0])
                OFF_CTRL:   b = ctrl;
                OFF_DIVLO:  b = div[7:0];
                OFF_DIVHI:  b = div[15:8];
                OFF_STATUS: b = status;
                default:    b = 8'h00;
            endcase
        end else begin
            b = 8'h00;
        end
        return b;
    endfunction

    assign busy_s   = (state_q != IDLE);
    assign status_s = {4'(fifo_count_s), ovf_q, busy_s, fifo_empty_s, fifo_full_s};
    assign ctrl_s   = {6'b000000, ctrl_par_q, ctrl_ie_q};
    assign waddr1_s = dwrite_addr + 16'd1;
    assign wsel_s[0] = (dwrite_en[0] && (dwrite_addr[15:3] == BASEADDR[15:3])) ? dwrite_addr[2:0] : OFF_NONE;
    assign wsel_s[1] = (dwrite_en[1] && (waddr1_s[15:3] == BASEADDR[15:3])) ? waddr1_s[2:0] : OFF_NONE;

    // Per-lane register writes and the registered read port.
    always_comb begin
        ctrl_ie_d  = ctrl_ie_q;
        ctrl_par_d = ctrl_par_q;
        div_d      = div_q;
        push_s     = 1'b0;
        ovf_clr_s  = 1'b0;
        for (int l = 0; l < 2; l++) begin
            case (wsel_s[l])
                OFF_TXDATA: push_s = 1'b1;
                OFF_CTRL: begin
                    ctrl_ie_d = dwrite_data[8*l + CTRL_IE];
`ifdef UART_TX_PARITY_EN
                    ctrl_par_d = dwrite_data[8*l + CTRL_PAR];
`endif
                end
                OFF_DIVLO:  div_d[7:0]  = dwrite_data[8*l +: 8];
                OFF_DIVHI:  div_d[15:8] = dwrite_data[8*l +: 8];
                OFF_STATUS: ovf_clr_s   = dwrite_data[8*l + ST_OVF];
                default:    ;
            endcase
        end
        if (push_s && fifo_full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        irq_d   = ctrl_ie_q & fifo_empty_s & ~busy_s;
        rdata_d = {reg_byte(dread_addr + 16'd1, ctrl_s, div_q, status_s),
                   reg_byte(dread_addr, ctrl_s, div_q, status_s)};
    end

    // Shifter next state; the shift register rotates so its parity is preserved.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        baud_d   = baud_q - 16'd1;
        pop_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s    = 1'b1;
                    shift_d  = fifo_dout_s;
                    bitcnt_d = 3'd0;
                    baud_d   = div_q;
                    state_d  = START;
                end else begin
                    baud_d   = baud_q;
                end
            end
            START: begin
                if (baud_q == 16'd0) begin
                    baud_d  = div_q;
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d   = div_q;
                    shift_d  = {shift_q[0], shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    state_d  = (bitcnt_q == 3'd7) ? (ctrl_par_q ? PARITY : STOP) : DATA;
`else
                    state_d  = (bitcnt_q == 3'd7) ? STOP : DATA;
`endif
                end else begin
                    state_d  = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_q == 16'd0) begin
                    baud_d  = div_q;
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                // Pop in the last stop cycle so back-to-back frames have no idle gap.
                if (baud_q == 16'd0 && !fifo_empty_s) begin
                    pop_s    = 1'b1;
                    shift_d  = fifo_dout_s;
                    bitcnt_d = 3'd0;
                    baud_d   = div_q;
                    state_d  = START;
                end else if (baud_q == 16'd0) begin
                    baud_d   = div_q;
                    state_d  = IDLE;
                end else begin
                    state_d  = STOP;
                end
            end
            default: begin
                baud_d  = div_q;
                state_d = IDLE;
            end
        endcase
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = even_parity(shift_d);
`endif
            default: txd_d = 1'b1;
        endcase
    end

    // Register state; txd is forced idle-high asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bitcnt_q   <= 3'd0;
            baud_q     <= 16'd0;
            div_q      <= DEFAULT_DIV;
            rdata_q    <= 16'h0000;
            ctrl_ie_q  <= 1'b0;
            ctrl_par_q <= 1'b0;
            ovf_q      <= 1'b0;
            txd_q      <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            baud_q     <= baud_d;
            div_q      <= div_d;
            rdata_q    <= rdata_d;
            ctrl_ie_q  <= ctrl_ie_d;
            ctrl_par_q <= ctrl_par_d;
            ovf_q      <= ovf_d;
            txd_q      <= txd_d;
            irq_q      <= irq_d;
        end
    end

    assign dread_data = rdata_q;
    assign txd        = txd_q;
    assign interrupt  = irq_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed self-checking bench for uart_tx_periph; parity cases run when
// UART_TX_PARITY_EN is defined.
module tb_uart_tx_periph;
    localparam logic [15:0] BASE = 16'h0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dread_addr = 16'h0000;
    logic [15:0] dread_data;
    logic [15:0] dwrite_addr = 16'h0000;
    logic [15:0] dwrite_data = 16'h0000;
    logic [1:0]  dwrite_en = 2'b00;
    logic        txd;
    logic        interrupt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_periph dut (
        .clk         (clk),
        .reset       (reset),
        .dread_addr  (dread_addr),
        .dread_data  (dread_data),
        .dwrite_addr (dwrite_addr),
        .dwrite_data (dwrite_data),
        .dwrite_en   (dwrite_en),
        .txd         (txd),
        .interrupt   (interrupt)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] en);
        dwrite_addr = addr;
        dwrite_data = data;
        dwrite_en   = en;
        tick();
        dwrite_en   = 2'b00;
    endtask

    task automatic rd(input logic [15:0] addr, output logic [15:0] data);
        dread_addr = addr;
        tick();
        data = dread_data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Waits (bounded) for the start bit, then checks txd every cycle and BUSY from cycle 1.
    task automatic expect_frame(input string tag, input logic [7:0] data, input int div,
                                input bit par, output int waited);
        int   bitlen;
        int   nbits;
        int   b;
        logic exp_b;
        bitlen = div + 1;
        nbits  = par ? 11 : 10;
        dread_addr = BASE + 16'd4;
        waited = 0;
        while (txd !== 1'b0 && waited < 64) begin
            tick();
            waited++;
        end
        check_eq({tag, "_start_seen"}, txd, 1'b0);
        for (int c = 0; c < nbits * bitlen; c++) begin
            b = c / bitlen;
            if (b == 0) exp_b = 1'b0;
            else if (b <= 8) exp_b = data[b-1];
            else if (b == 9 && par) exp_b = ^data;
            else exp_b = 1'b1;
            check_eq($sformatf("%s_txd_c%0d", tag, c), txd, exp_b);
            if (c > 0) check_eq($sformatf("%s_busy_c%0d", tag, c), dread_data[2], 1'b1);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] r;
        int          w;

        // Reset state
        tick();
        check_eq("rst_txd", txd, 1'b1);
        check_eq("rst_irq", interrupt, 1'b0);
        check_eq("rst_rdata", dread_data, 16'h0000);
        tick();
        reset = 1'b0;
        tick();
        rd(BASE + 16'd4, r); check_eq("rst_status", r, 16'h0002);
        rd(BASE + 16'd2, r); check_eq("rst_div", r, 16'd103);
        rd(BASE + 16'd3, r); check_eq("rst_divhi_status", r, 16'h0200);
        check_eq("idle_txd", txd, 1'b1);
        check_eq("idle_irq", interrupt, 1'b0);

        // Single 8N1 frame
        wr(BASE + 16'd2, 16'd3, 2'b11);
        rd(BASE + 16'd2, r); check_eq("div3", r, 16'h0003);
        wr(BASE, 16'h00A5, 2'b01);
        expect_frame("a5", 8'hA5, 3, 1'b0, w);
        check_eq("a5_latency", 16'(w), 16'd1);
        check_eq("a5_idle_txd", txd, 1'b1);
        rd(BASE + 16'd4, r); check_eq("a5_status_after", r, 16'h0002);

        // Interrupt after two back-to-back frames
        wr(BASE, 16'h0111, 2'b11);
        wr(BASE, 16'h0022, 2'b01);
        check_eq("irq_low_queued", interrupt, 1'b0);
        expect_frame("f11", 8'h11, 3, 1'b0, w);
        check_eq("irq_low_mid", interrupt, 1'b0);
        expect_frame("f22", 8'h22, 3, 1'b0, w);
        check_eq("b2b_no_gap", 16'(w), 16'd0);
        check_eq("irq_low_at_idle", interrupt, 1'b0);
        tick();
        check_eq("irq_high", interrupt, 1'b1);
        wr(BASE, 16'h0033, 2'b01);
        tick();
        check_eq("irq_dropped", interrupt, 1'b0);
        do_reset();

        // Overflow
        wr(BASE + 16'd2, 16'd100, 2'b11);
        for (int i = 0; i < 6; i++) wr(BASE, 16'(8'h60 + i), 2'b01);
        rd(BASE + 16'd4, r); check_eq("ovf_status", r, 16'h004D);
        wr(BASE + 16'd4, 16'h0008, 2'b01);
        rd(BASE + 16'd4, r); check_eq("ovf_cleared", r, 16'h0045);
        wr(BASE + 16'd5, 16'hFFFF, 2'b11);
        rd(BASE + 16'd4, r); check_eq("reserved_wr_ignored", r, 16'h0045);
        rd(BASE + 16'd5, r); check_eq("reserved_rd", r, 16'h0000);
        do_reset();

        // Dual-lane writes and read window
        wr(BASE + 16'd2, 16'h0107, 2'b11);
        rd(BASE + 16'd2, r); check_eq("dual_div", r, 16'h0107);
        wr(BASE, 16'h0141, 2'b11);
        rd(BASE + 16'd4, r); check_eq("dual_push_status", r, 16'h0010);
        rd(BASE, r); check_eq("dual_ctrl", r, 16'h0100);
        rd(16'h0100, r); check_eq("out_of_window", r, 16'h0000);
        rd(BASE + 16'd7, r); check_eq("top_edge", r, 16'h0000);
        rd(BASE + 16'd1, r); check_eq("ctrl_divlo", r, 16'h0701);
        check_eq("irq_busy_low", interrupt, 1'b0);
        do_reset();

        // CTRL.PAR writability
        wr(BASE + 16'd1, 16'h0003, 2'b01);
        rd(BASE, r);
`ifdef UART_TX_PARITY_EN
        check_eq("ctrl_par", r, 16'h0300);
`else
        check_eq("ctrl_par", r, 16'h0100);
`endif
        do_reset();

        // Reset asserted mid-frame
        wr(BASE + 16'd2, 16'd3, 2'b11);
        wr(BASE, 16'h0000, 2'b01);
        w = 0;
        while (txd !== 1'b0 && w < 64) begin tick(); w++; end
        for (int i = 0; i < 6; i++) tick();
        check_eq("mid_data_low", txd, 1'b0);
        #2 reset = 1'b1;
        #1 check_eq("async_rst_txd", txd, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        rd(BASE + 16'd4, r); check_eq("rst_mid_status", r, 16'h0002);
        rd(BASE + 16'd2, r); check_eq("rst_mid_div", r, 16'd103);
        check_eq("rst_mid_txd", txd, 1'b1);

`ifdef UART_TX_PARITY_EN
        // Even parity frames at DIV=0
        wr(BASE + 16'd2, 16'h0000, 2'b11);
        wr(BASE + 16'd1, 16'h0002, 2'b01);
        wr(BASE, 16'h0007, 2'b01);
        expect_frame("par07", 8'h07, 0, 1'b1, w);
        check_eq("par07_latency", 16'(w), 16'd1);
        wr(BASE, 16'h0003, 2'b01);
        expect_frame("par03", 8'h03, 0, 1'b1, w);
        rd(BASE + 16'd4, r); check_eq("par_status_after", r, 16'h0002);
        wr(BASE, 16'h0000, 2'b01);
        tick();
        tick();
        check_eq("par_mid_data_low", txd, 1'b0);
        #2 reset = 1'b1;
        #1 check_eq("par_async_rst_txd", txd, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        rd(BASE + 16'd4, r); check_eq("par_rst_status", r, 16'h0002);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter that responds on the CPU data bus, in the I/O region below the memory base.
- CPU writes bytes into a small TX FIFO; a baud-rate shifter serialises them as 8N1 frames on txd.
- Exposes status and a divisor register, and raises a level interrupt when the FIFO drains.

Parameters:
- BASEADDR, 16'h0010, byte address of register block; 8 bytes decoded, BASEADDR[2:0] must be 0
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, at least 2
- DEFAULT_DIV, 16'd103, reset value of DIVISOR; bit period is DIVISOR+1 clk cycles

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dread_addr  in  16  read byte address, sampled every posedge
- dread_data  out  16  registered read data: [7:0]=reg(addr), [15:8]=reg(addr+1)
- dwrite_addr  in  16  write byte address
- dwrite_data  in  16  write data: lane0 [7:0] to addr, lane1 [15:8] to addr+1
- dwrite_en  in  2  per-lane write strobe
- txd  out  1  serial output, idle high
- interrupt  out  1  level interrupt

Behaviour:
- Register map (byte offsets):
  - +0 TXDATA: write-only; a write pushes the byte into the FIFO; reads return 0.
  - +1 CTRL: bit0 IE (irq enable), bit1 PAR (see Optional Feature); other bits read 0.
  - +2 DIV_LO, +3 DIV_HI: DIVISOR[15:0], read/write.
  - +4 STATUS: bit0 FULL, bit1 EMPTY, bit2 BUSY, bit3 OVF (sticky), bits[7:4] FIFO count. Writing 1 to bit3 clears OVF; other bits read-only.
  - +5..+7: reserved; read 0, writes ignored.
  - Addresses outside BASEADDR..BASEADDR+7 read 0.
- Decoding is per byte lane. When both lanes hit in one cycle, both take effect.
- Read latency is exactly 1 cycle: dread_data is updated at posedge from the dread_addr present at that edge, so it matches a system that muxes on the registered address.
- STATUS read-back reflects the state before any same-cycle write.
- Reset values: dread_data=0, txd=1, interrupt=0, FIFO empty, OVF=0, CTRL=0, DIVISOR=DEFAULT_DIV, FSM IDLE.
- FIFO:
  - Push to TXDATA when FULL: byte dropped, OVF set.
  - Push while full and pop in the same cycle: push accepted.
  - Count is 0..FIFO_DEPTH.
- Shifter FSM (states IDLE, START, DATA, STOP):
  - IDLE: txd=1. If the FIFO is non-empty, pop into the shift register, load the bit counter, and go to START on the next cycle.
  - START: txd=0 for DIVISOR+1 cycles.
  - DATA: 8 bits, LSB first, each DIVISOR+1 cycles.
  - STOP: txd=1 for DIVISOR+1 cycles, then IDLE; back-to-back frames add no extra idle cycle (pop happens in the final STOP cycle).
- Baud counter: 16-bit down-counter, reloaded with DIVISOR at every bit boundary. A DIVISOR write mid-frame takes effect at the next reload. DIVISOR=0 gives 1-cycle bits.
- BUSY = FSM not IDLE.
- interrupt = IE & EMPTY & !BUSY, registered (1-cycle delay).
- Reset asserted mid-frame: txd returns to 1 immediately (async) and FIFO contents are discarded.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: CTRL.PAR is writable. PAR=1 inserts an even-parity bit (XOR of the 8 data bits) between DATA and STOP, lasting DIVISOR+1 cycles; the FSM gains a PARITY state. PAR=0 behaves as 8N1.
- Undefined: CTRL bit1 reads 0, writes are ignored, no PARITY state exists.

Decomposition:
- Package uart_tx_pkg:
  - register offset localparams: OFF_TXDATA, OFF_CTRL, OFF_DIVLO, OFF_DIVHI, OFF_STATUS
  - STATUS/CTRL bit-index constants
  - enum tx_state_t {IDLE, START, DATA, STOP[, PARITY]}
- Sub-module tx_fifo: synchronous FIFO, parameter DEPTH, width 8.
  - Ports: clk, reset, push, din, pop, dout, full, empty, count.
  - Show-ahead dout.

Test Plan:
- Reset values: reset, then read +4 -> dread_data[7:0]=8'h02 one cycle later; read +2 -> 16'd103; txd=1; interrupt=0.
- Single frame: write DIV=16'd3, then write 8'hA5 to +0 -> txd start low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles; BUSY=1 throughout.
- Overflow: DIV=16'd100, write 6 bytes back-to-back -> first byte in shifter, FIFO holds 4, last byte dropped, STATUS=8'h4D (count 4, OVF, BUSY, FULL); write 8'h08 to +4 -> OVF cleared.
- Interrupt: IE=1, queue 2 bytes -> interrupt=0 until the second stop bit ends, then 1 one cycle later; writing another byte drops interrupt.
- Dual-lane and read latency: 16-bit write 16'h0107 at +2 -> DIVISOR=16'h0107; 16-bit write 16'h0141 at +0 -> push 8'h41 and IE=1 in the same cycle; reads of out-of-window address 16'h0100 -> 0.
- With UART_TX_PARITY_EN: PAR=1, DIV=0, send 8'h07 -> parity bit 1 before stop, frame 11 cycles; reset asserted mid-DATA -> txd=1 immediately, STATUS=8'h02 after release.
